// File: rtl/wide_add_pkg.sv
// Shared definitions for the wide multi-limb add sequencer.
package wide_add_pkg;

   // Width of one limb handled by the shared adder per cycle.
   localparam int LIMB_W = 64;

   // Carry-skip group size inside the limb adder.
   localparam int SKIP_BLK = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : wide_add_pkg

// File: rtl/carry_skip_adder.sv
// 64-bit carry-skip adder: ripple within 4-bit groups, with the group carry
// bypassing the ripple chain whenever every bit of the group propagates.
module carry_skip_adder
   import wide_add_pkg::*;
(
   input  logic [LIMB_W-1:0] a,
   input  logic [LIMB_W-1:0] b,
   input  logic              cin,
   output logic [LIMB_W-1:0] sum,
   output logic              cout
);

   localparam int N_BLK = LIMB_W / SKIP_BLK;

   logic [LIMB_W-1:0] sum_s;
   logic              carry_s;
   logic              blk_cin_s;
   logic              blk_prop_s;
   logic              bit_p_s;

   // Group-wise ripple with skip multiplexer on each group carry-out.
   always_comb begin
      sum_s      = '0;
      carry_s    = cin;
      blk_cin_s  = 1'b0;
      blk_prop_s = 1'b0;
      bit_p_s    = 1'b0;
      for (int blk = 0; blk < N_BLK; blk++) begin
         blk_cin_s  = carry_s;
         blk_prop_s = 1'b1;
         for (int j = 0; j < SKIP_BLK; j++) begin
            bit_p_s                  = a[blk*SKIP_BLK + j] ^ b[blk*SKIP_BLK + j];
            sum_s[blk*SKIP_BLK + j]  = bit_p_s ^ carry_s;
            carry_s                  = (a[blk*SKIP_BLK + j] & b[blk*SKIP_BLK + j]) | (bit_p_s & carry_s);
            blk_prop_s               = blk_prop_s & bit_p_s;
         end
         if (blk_prop_s) begin
            carry_s = blk_cin_s;
         end else begin
            carry_s = carry_s;
         end
      end
   end

   assign sum  = sum_s;
   assign cout = carry_s;

endmodule : carry_skip_adder

// File: rtl/wide_add_sequencer.sv
// LIMBS x 64-bit adder that streams one limb per cycle through a single
// carry_skip_adder, least-significant limb first, chaining the carry in a
// register and holding the full-width result until the consumer takes it.
module wide_add_sequencer
   import wide_add_pkg::*;
#(
   parameter int LIMBS = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LIMB_W*LIMBS-1:0] a,
   input  logic [LIMB_W*LIMBS-1:0] b,
   input  logic                    cin,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LIMB_W*LIMBS-1:0] sum,
   output logic                    cout,
   output logic                    busy
);

   localparam int IDX_W = $clog2(LIMBS);
   localparam int TOT_W = LIMB_W * LIMBS;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LIMBS - 1);

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q,   idx_d;
   logic              carry_q, carry_d;
   logic [TOT_W-1:0]  a_q,     a_d;
   logic [TOT_W-1:0]  b_q,     b_d;
   logic [TOT_W-1:0]  sum_q,   sum_d;
   logic              cout_q,  cout_d;

   logic [LIMB_W-1:0] add_a_s;
   logic [LIMB_W-1:0] add_b_s;
   logic [LIMB_W-1:0] add_sum_s;
   logic              add_cout_s;

   // Select the active limb of each operand for the shared adder.
   always_comb begin
      add_a_s = a_q[idx_q*LIMB_W +: LIMB_W];
      add_b_s = b_q[idx_q*LIMB_W +: LIMB_W];
   end

   carry_skip_adder u_adder (
      .a    (add_a_s),
      .b    (add_b_s),
      .cin  (carry_q),
      .sum  (add_sum_s),
      .cout (add_cout_s)
   );

   // A new operand pair may enter when idle, or when the pending result
   // leaves on this same edge.
   assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);

   // Next-state and datapath update for the limb sequencer.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               idx_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            sum_d[idx_q*LIMB_W +: LIMB_W] = add_sum_s;
            carry_d                       = add_cout_s;
            if (idx_q == LAST_IDX) begin
               cout_d  = add_cout_s;
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
            end
         end
         DONE: begin
            if (out_ready && in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               idx_d   = '0;
               state_d = RUN;
            end else if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // State and datapath registers; reset discards any in-flight addition.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == RUN);
   assign sum       = sum_q;
   assign cout      = cout_q;

endmodule : wide_add_sequencer

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer (LIMBS=4). Expected results come
// from plain 257-bit arithmetic on the captured operands.
module tb_wide_add_sequencer;

   localparam int L = 4;
   localparam int W = 64 * L;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         busy;

   int checks = 0;
   int errors = 0;

   wide_add_sequencer #(.LIMBS(L)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] rand_w();
      logic [W-1:0] r;
      for (int i = 0; i < W/32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
   endfunction

   // Present operands until accepted; returns at acceptance edge + 1.
   task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, output int ok);
      int n;
      a = x; b = y; cin = c; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1; n++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      ok = (n < 20) ? 1 : 0;
   endtask

   // Count edges until out_valid; -1 if the budget runs out.
   task automatic wait_done(output int lat);
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1; lat++;
      end
      if (!out_valid) lat = -1;
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (sum !== '0)         begin errors++; $display("FAIL reset_sum got %h exp 0", sum); end
      checks++; if (cout !== 1'b0)      begin errors++; $display("FAIL reset_cout got %b exp 0", cout); end
   endtask

   task automatic test_full_carry();
      int ok, lat, busy_cnt;
      logic [W-1:0] x;
      x = '1;
      start_op(x, {{(W-1){1'b0}}, 1'b1}, 1'b0, ok);
      busy_cnt = 0; lat = 0;
      while (!out_valid && lat < 50) begin
         if (busy) busy_cnt++;
         @(posedge clk); #1; lat++;
      end
      checks++; if (ok != 1 || lat != L) begin errors++; $display("FAIL full_carry_latency got %0d exp %0d", lat, L); end
      checks++; if (busy_cnt != L) begin errors++; $display("FAIL full_carry_busy_cycles got %0d exp %0d", busy_cnt, L); end
      checks++; if (sum !== '0 || cout !== 1'b1) begin errors++; $display("FAIL full_carry_result got %h/%b exp 0/1", sum, cout); end
      release_out();
   endtask

   task automatic test_directed();
      int ok, lat;
      logic [W-1:0] e;
      start_op(W'(1), W'(2), 1'b1, ok);
      wait_done(lat);
      checks++; if (sum !== W'(4) || cout !== 1'b0 || lat != L) begin errors++; $display("FAIL small_add got %h/%b lat %0d exp 4/0 lat %0d", sum, cout, lat, L); end
      release_out();
      e = '0; e[64] = 1'b1;
      start_op(W'(64'hFFFF_FFFF_FFFF_FFFF), W'(1), 1'b0, ok);
      wait_done(lat);
      checks++; if (sum !== e || cout !== 1'b0) begin errors++; $display("FAIL limb_boundary got %h/%b exp %h/0", sum, cout, e); end
      release_out();
   endtask

   task automatic test_stall_back_to_back();
      int ok, lat;
      logic [W-1:0] x, y, s0;
      logic [W:0]   r;
      logic         c0;
      x = rand_w(); y = rand_w(); r = model(x, y, 1'b1);
      start_op(x, y, 1'b1, ok);
      wait_done(lat);
      s0 = sum; c0 = cout;
      checks++; if (s0 !== r[W-1:0] || c0 !== r[W]) begin errors++; $display("FAIL stall_first got %h/%b exp %h/%b", s0, c0, r[W-1:0], r[W]); end
      in_valid = 1'b1; a = rand_w(); b = rand_w();
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (sum !== s0 || cout !== c0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL stall_hold cyc %0d got sum %h cout %b ov %b ir %b", i, sum, cout, out_valid, in_ready);
         end
      end
      a = W'(10); b = W'(20); cin = 1'b0; out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b exp 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_capture got ov %b busy %b exp 0/1", out_valid, busy); end
      wait_done(lat);
      checks++; if (lat != L || sum !== W'(30) || cout !== 1'b0) begin errors++; $display("FAIL b2b_result got %h/%b lat %0d exp 30/0 lat %0d", sum, cout, lat, L); end
      release_out();
   endtask

   task automatic test_ignore_during_run();
      int ok, lat;
      logic [W-1:0] x, y;
      logic [W:0]   r;
      x = rand_w(); y = rand_w(); r = model(x, y, 1'b0);
      start_op(x, y, 1'b0, ok);
      a = rand_w(); b = rand_w(); cin = 1'b1; in_valid = 1'b1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL run_in_ready got %b exp 0", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_done(lat);
      checks++; if (lat != L - 1 || sum !== r[W-1:0] || cout !== r[W]) begin errors++; $display("FAIL run_ignore got %h/%b exp %h/%b", sum, cout, r[W-1:0], r[W]); end
      release_out();
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL idle_after_release got ov %b busy %b ir %b", out_valid, busy, in_ready); end
   endtask

   task automatic test_reset_midrun();
      int ok, lat, spurious;
      start_op(rand_w() | W'(1), rand_w() | W'(1), 1'b1, ok);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || sum !== '0 || cout !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL midrun_reset got ov %b busy %b sum %h cout %b ir %b", out_valid, busy, sum, cout, in_ready);
      end
      #1 rst_n = 1'b1;
      spurious = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (out_valid || busy) spurious++;
      end
      checks++; if (spurious != 0) begin errors++; $display("FAIL midrun_no_result got %0d active cycles exp 0", spurious); end
      start_op(W'(5), W'(7), 1'b0, ok);
      wait_done(lat);
      checks++; if (lat != L || sum !== W'(12) || cout !== 1'b0) begin errors++; $display("FAIL post_reset got %h/%b lat %0d exp 12/0", sum, cout, lat); end
      release_out();
   endtask

   task automatic test_random();
      int ok, lat;
      logic [W-1:0] x, y;
      logic         c;
      logic [W:0]   r;
      for (int t = 0; t < 20; t++) begin
         x = rand_w(); y = rand_w(); c = 1'($urandom_range(0, 1));
         if (t % 5 == 0) y = ~x;
         r = model(x, y, c);
         start_op(x, y, c, ok);
         wait_done(lat);
         for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
            @(posedge clk); #1;
         end
         checks++;
         if (ok != 1 || lat != L || sum !== r[W-1:0] || cout !== r[W]) begin
            errors++; $display("FAIL random_%0d got %h/%b lat %0d exp %h/%b", t, sum, cout, lat, r[W-1:0], r[W]);
         end
         release_out();
      end
   endtask

   task automatic test_back_to_back();
      logic [W:0] exp_q[$];
      logic [W:0] e;
      logic [W-1:0] x, y;
      logic c, accept;
      int sent, got, last_cyc;
      sent = 0; got = 0; last_cyc = -1;
      out_ready = 1'b1;
      x = rand_w(); y = rand_w(); c = 1'($urandom_range(0, 1));
      a = x; b = y; cin = c; in_valid = 1'b1;
      for (int cyc = 0; cyc < 200 && got < 6; cyc++) begin
         #1;
         if (out_valid) begin
            checks++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            if (sum !== e[W-1:0] || cout !== e[W]) begin errors++; $display("FAIL b2b_stream_%0d got %h/%b exp %h/%b", got, sum, cout, e[W-1:0], e[W]); end
            if (last_cyc >= 0) begin
               checks++;
               if (cyc - last_cyc != L + 1) begin errors++; $display("FAIL b2b_spacing got %0d exp %0d", cyc - last_cyc, L + 1); end
            end
            last_cyc = cyc;
            got++;
         end
         accept = in_valid && in_ready;
         @(posedge clk); #1;
         if (accept) begin
            exp_q.push_back(model(x, y, c));
            sent++;
            x = rand_w(); y = rand_w(); c = 1'($urandom_range(0, 1));
            a = x; b = y; cin = c;
            if (sent >= 6) in_valid = 1'b0;
         end
         #3;
      end
      checks++; if (got != 6) begin errors++; $display("FAIL b2b_count got %0d exp 6", got); end
      in_valid = 1'b0;
      out_ready = 1'b0;
      repeat (L + 2) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_full_carry();
      test_directed();
      test_stall_back_to_back();
      test_ignore_during_run();
      test_reset_midrun();
      test_random();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_wide_add_sequencer

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Multi-cycle sequencer that computes a `LIMBS`×64-bit addition by streaming one 64-bit limb per cycle through a single shared `carry_skip_adder`, least-significant limb first. It chains the carry through a register between limbs and assembles the full-width result. It sits between the operand source and the result consumer, with valid/ready handshakes on both sides. Wide additions therefore reuse one 64-bit adder instead of instantiating a `LIMBS`×64-bit adder.

## Interface
- `LIMBS`, 4: number of 64-bit limbs per operand; legal range 2..16.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `in_valid` input 1: operand source has `a`, `b`, `cin` valid.
- `in_ready` output 1: sequencer can accept operands this cycle.
- `a` input 64*LIMBS: operand A.
- `b` input 64*LIMBS: operand B.
- `cin` input 1: carry into limb 0.
- `out_valid` output 1: `sum`/`cout` hold a completed result.
- `out_ready` input 1: consumer accepts the result this cycle.
- `sum` output 64*LIMBS: registered full-width sum.
- `cout` output 1: registered carry out of the top limb.
- `busy` output 1: high while in RUN.

## Operation
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`: capture `a`, `b` into operand registers, set `carry_r`=`cin`, set `idx`=0, go to RUN.
  - RUN: adder inputs are `a_r[idx]`, `b_r[idx]`, `carry_r`. Each edge writes the adder sum into `sum_r[idx]` and sets `carry_r`=adder cout. If `idx`==LIMBS-1, latch `cout`=adder cout and go to DONE; otherwise `idx`++.
  - DONE: `out_valid`=1. `sum` and `cout` are held stable until `out_ready`.
    - `out_ready` && !`in_valid` → IDLE.
    - `out_ready` && `in_valid` → capture new operands and go directly to RUN (back-to-back).
- `in_ready` is combinational: (state==IDLE) || (state==DONE && `out_ready`).
- `in_valid` while in RUN, or in DONE without `out_ready`, is ignored. Operand-input changes during RUN do not affect the result, because operands are registered.
- Arithmetic: modulo 2^(64*LIMBS) plus `cout`; the result is unsigned. `idx` width is $clog2(LIMBS).
- `sum` is not cleared after the output handshake; it keeps the last result until the next limb-0 write.
- Reset (async, any state): state=IDLE, `idx`=0, `carry_r`=0, `sum_r`=0, `cout`=0, operand registers=0. Any in-flight operation is discarded and not reported.
- Reset value of every output: `in_ready`=1 (IDLE), `out_valid`=0, `busy`=0, `sum`=0, `cout`=0.

## Timing
- Operand acceptance at edge E0 (`in_valid` && `in_ready`).
- Limb k is written at edge E(k+1).
- `out_valid` rises after edge E(LIMBS); latency is LIMBS cycles from acceptance.
- Throughput with `out_ready` tied high: one result every LIMBS+1 cycles. This includes the single DONE cycle, where the back-to-back capture overlaps the output handshake.
- The adder path is combinational from `a_r`/`b_r`/`carry_r`/`idx` to `sum_r`/`carry_r`. The critical path is the limb mux plus the 64-bit carry-skip chain plus the register.

## Structure
- Package `wide_add_pkg`:
  - `LIMB_W`=64.
  - `state_t` enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- Sub-module: one `carry_skip_adder` instance, 64-bit, the only arithmetic in the block.
- Limb select is an indexed part-select on the operand registers. Limb write-back is an indexed part-select into `sum_r`.

## Test plan
- LIMBS=4, a=2^256-1, b=1, cin=0 → `sum`=0, `cout`=1. `out_valid` asserts exactly 4 edges after acceptance and `busy` is high for 4 cycles.
- a=1, b=2, cin=1 → `sum`=4, `cout`=0.
- a=64'hFFFF_FFFF_FFFF_FFFF (limb 0 only), b=1 → `sum`=2^64 (limb1=1, limb0=0), `cout`=0. Carry crosses the limb boundary via `carry_r`.
- Hold `out_ready`=0 for 5 cycles in DONE → `sum`/`cout`/`out_valid` stay stable and `in_ready`=0. Then `out_ready`=1 with `in_valid`=1, a=10, b=20 → both handshakes occur on one edge, and the next `out_valid` comes 4 edges later with `sum`=30.
- Change `a`/`b` and pulse `in_valid` during RUN → ignored; the result matches the originally captured operands.
- Assert `rst_n`=0 after 2 RUN cycles → `out_valid`=0, `busy`=0, `sum`=0 immediately, with no result produced. After release, a=5, b=7, cin=0 → `sum`=12 after 4 edges.
